// File: rtl/scm_fifo_ctrl.sv
// scm_fifo_ctrl
//    FIFO controller for a 1R/1W latch-based SCM register file. It turns a
//    valid/ready input stream into SCM write/read commands and presents a
//    valid/ready output stream. The head word is prefetched from the SCM.
//    The SCM samples write data at the clock edge. Its read address is
//    registered, so read data arrives one cycle after scm_re_o.
//
//    Parameters
//       ADDR_WIDTH  SCM address width; depth is 2**ADDR_WIDTH
//       DATA_WIDTH  word width
//
//    Ports
//       clk, rst                 clock, synchronous active-high reset
//       in_valid_i/in_ready_o    push handshake, in_data_i carries the word
//       out_valid_o/out_ready_i  pop handshake, out_data_o is the head word
//       occupancy_o              words pushed and not yet popped
//       scm_re_o/scm_raddr_o     SCM read command, scm_rdata_i is its data
//       scm_we_o/scm_waddr_o/scm_wdata_o  SCM write command
//       flush_i                  synchronous clear (SCM_FIFO_CTRL_FLUSH_EN only)
//
//    Build option
//       SCM_FIFO_CTRL_FLUSH_EN   adds flush_i, which clears like rst
module scm_fifo_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef SCM_FIFO_CTRL_FLUSH_EN
   input  logic                  flush_i,
`endif
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic [ADDR_WIDTH:0]   occupancy_o,
   output logic                  scm_re_o,
   output logic [ADDR_WIDTH-1:0] scm_raddr_o,
   input  logic [DATA_WIDTH-1:0] scm_rdata_i,
   output logic                  scm_we_o,
   output logic [ADDR_WIDTH-1:0] scm_waddr_o,
   output logic [DATA_WIDTH-1:0] scm_wdata_o
);

   localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0] wrPtr;
   logic [ADDR_WIDTH:0] rdPtr;
   logic [ADDR_WIDTH:0] occCnt;
   logic                outValidQ;

   logic clear;
   logic push;
   logic pop;
   logic rdIssue;

`ifdef SCM_FIFO_CTRL_FLUSH_EN
   assign clear = rst | flush_i;
`else
   assign clear = rst;
`endif

   // Full is judged from registered occupancy only; a pop this cycle frees
   // a slot for the next cycle, keeping out_ready_i off the in_ready_o path.
   assign in_ready_o = (occCnt != FULL_CNT);

   // Commands are suppressed during a clear so nothing lands in the SCM and
   // no read is launched for a word that is about to be discarded.
   assign push    = in_valid_i & in_ready_o & ~clear;
   assign pop     = outValidQ & out_ready_i & ~clear;
   assign rdIssue = (rdPtr != wrPtr) & (~outValidQ | out_ready_i) & ~clear;

   assign scm_we_o    = push;
   assign scm_waddr_o = wrPtr[ADDR_WIDTH-1:0];
   assign scm_wdata_o = in_data_i;

   assign scm_re_o    = rdIssue;
   assign scm_raddr_o = rdPtr[ADDR_WIDTH-1:0];

   // The SCM read port only moves on scm_re_o, so its data stays put while
   // the head word waits for the consumer.
   assign out_data_o  = scm_rdata_i;
   assign out_valid_o = outValidQ;
   assign occupancy_o = occCnt;

   // Occupancy keeps the displayed word counted until it is popped. That
   // stops the writer from reusing the slot the SCM is still showing.
   always_ff @(posedge clk) begin
      if (clear) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         occCnt    <= '0;
         outValidQ <= 1'b0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + CNT_ONE;
         end
         if (rdIssue) begin
            rdPtr <= rdPtr + CNT_ONE;
         end
         if (rdIssue) begin
            outValidQ <= 1'b1;
         end else if (out_ready_i) begin
            outValidQ <= 1'b0;
         end
         if (push && !pop) begin
            occCnt <= occCnt + CNT_ONE;
         end else if (pop && !push) begin
            occCnt <= occCnt - CNT_ONE;
         end
      end
   end

endmodule
